// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: sequences mole appearances, times the visible
// and hidden phases from a tick strobe, scores hits, counts misses and ends the
// game after a configurable number of misses.
module mole_round_ctrl #(
  parameter int unsigned UP_TICKS   = 32,  // base visible time in ticks (4..255)
  parameter int unsigned DOWN_TICKS = 8,   // hidden gap in ticks (1..255)
  parameter int unsigned MAX_MISSES = 5    // misses that end the game (1..15)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [1:0] i_difficulty,
  input  logic       i_whack_valid,
  input  logic [2:0] i_whack_pos,
  input  logic [2:0] i_mole_pos,
  output logic       o_change_position,
  output logic       o_mole_visible,
  output logic       o_hit,
  output logic [7:0] o_score,
  output logic [3:0] o_misses,
  output logic       o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_UP,
    S_DOWN,
    S_OVER
  } state_t;

  localparam logic [7:0] UP_BASE    = 8'(UP_TICKS);
  localparam logic [7:0] DOWN_LOAD  = 8'(DOWN_TICKS);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_change_position;
  logic       r_mole_visible;
  logic       r_hit;
  logic [7:0] r_score;
  logic [3:0] r_misses;
  logic       r_game_over;

  logic [7:0] w_up_load;
  logic       w_whack_hit;
  logic [3:0] w_misses_inc;

  // Difficulty-scaled visible time, kept at least one tick so an expiry can always happen.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_up_load = UP_BASE >> i_difficulty;
    if (w_up_load == 8'd0) begin
      w_up_load = 8'd1;
    end
  end

  assign w_whack_hit  = i_whack_valid && (i_whack_pos == i_mole_pos);
  assign w_misses_inc = r_misses + 4'd1;

  // Round state machine; all outputs are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= S_IDLE;
      r_timer           <= 8'd0;
      r_change_position <= 1'b0;
      r_mole_visible    <= 1'b0;
      r_hit             <= 1'b0;
      r_score           <= 8'd0;
      r_misses          <= 4'd0;
      r_game_over       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates throughout; pulse outputs default low and are
      // raised only on the transition that owns them.
      r_change_position <= 1'b0;
      r_hit             <= 1'b0;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (i_start) begin
            r_score           <= 8'd0;
            r_misses          <= 4'd0;
            r_game_over       <= 1'b0;
            r_change_position <= 1'b1;
            r_state           <= S_SPAWN;
          end
        end

        S_SPAWN: begin
          // Ticks in this cycle are deliberately not counted.
          r_timer        <= w_up_load;
          r_mole_visible <= 1'b1;
          r_state        <= S_UP;
        end

        S_UP: begin
          if (w_whack_hit) begin
            // A hit wins over a simultaneous expiry.
            r_hit          <= 1'b1;
            if (r_score != 8'hFF) begin
              r_score <= r_score + 8'd1;
            end
            r_timer        <= DOWN_LOAD;
            r_mole_visible <= 1'b0;
            r_state        <= S_DOWN;
          end else if (i_tick) begin
            if (r_timer == 8'd1) begin
              r_misses       <= w_misses_inc;
              r_mole_visible <= 1'b0;
              if (w_misses_inc == MISS_LIMIT) begin
                r_timer     <= 8'd0;
                r_game_over <= 1'b1;
                r_state     <= S_OVER;
              end else begin
                r_timer <= DOWN_LOAD;
                r_state <= S_DOWN;
              end
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        end

        S_DOWN: begin
          if (i_tick) begin
            if (r_timer == 8'd1) begin
              r_change_position <= 1'b1;
              r_state           <= S_SPAWN;
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_change_position = r_change_position;
  assign o_mole_visible    = r_mole_visible;
  assign o_hit             = r_hit;
  assign o_score           = r_score;
  assign o_misses          = r_misses;
  assign o_game_over       = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl: a directed vector table, hand-written
// corner sequences, and randomized play compared against a phase-level game model.
module tb_mole_round_ctrl;

  localparam int UP_T   = 32;
  localparam int DOWN_T = 8;
  localparam int MAXM   = 5;

  localparam int P_IDLE  = 0;
  localparam int P_SPAWN = 1;
  localparam int P_UP    = 2;
  localparam int P_DOWN  = 3;
  localparam int P_OVER  = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_difficulty = 2'd0;
  logic       i_whack_valid = 1'b0;
  logic [2:0] i_whack_pos = 3'd0;
  logic [2:0] i_mole_pos = 3'd0;
  logic       o_change_position;
  logic       o_mole_visible;
  logic       o_hit;
  logic [7:0] o_score;
  logic [3:0] o_misses;
  logic       o_game_over;

  int checks = 0;
  int errors = 0;

  // Game model: which phase the game is in, ticks left in that phase, counters.
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_score = 0;
  int m_miss  = 0;
  int m_hit   = 0;

  typedef struct {
    int tick; int start; int diff; int wv; int wp; int mp;
    int cp;   int vis;   int hit;  int score; int miss; int over;
  } vec_t;

  vec_t tbl[16];

  mole_round_ctrl dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_tick           (i_tick),
    .i_start          (i_start),
    .i_difficulty     (i_difficulty),
    .i_whack_valid    (i_whack_valid),
    .i_whack_pos      (i_whack_pos),
    .i_mole_pos       (i_mole_pos),
    .o_change_position(o_change_position),
    .o_mole_visible   (o_mole_visible),
    .o_hit            (o_hit),
    .o_score          (o_score),
    .o_misses         (o_misses),
    .o_game_over      (o_game_over)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int tick, int start, int diff, int wv, int wp, int mp,
                              int cp, int vis, int hit, int score, int miss, int over);
    vec_t v;
    v.tick = tick; v.start = start; v.diff = diff; v.wv = wv; v.wp = wp; v.mp = mp;
    v.cp = cp; v.vis = vis; v.hit = hit; v.score = score; v.miss = miss; v.over = over;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_score = 0;
    m_miss  = 0;
    m_hit   = 0;
  endtask

  // Advance the game by one clock given the inputs present at that edge.
  task automatic model_step(input int tick, input int start, input int diff,
                            input int wv, input int wp, input int mp);
    int hit_now;
    hit_now = 0;
    case (m_phase)
      P_IDLE, P_OVER: begin
        if (start != 0) begin
          m_score = 0;
          m_miss  = 0;
          m_phase = P_SPAWN;
        end
      end
      P_SPAWN: begin
        m_left = UP_T / (1 << diff);
        if (m_left < 1) m_left = 1;
        m_phase = P_UP;
      end
      P_UP: begin
        if (wv != 0 && wp == mp) begin
          hit_now = 1;
          if (m_score < 255) m_score++;
          m_left  = DOWN_T;
          m_phase = P_DOWN;
        end else if (tick != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_miss++;
            if (m_miss == MAXM) m_phase = P_OVER;
            else begin
              m_left  = DOWN_T;
              m_phase = P_DOWN;
            end
          end
        end
      end
      default: begin
        if (tick != 0) begin
          m_left--;
          if (m_left == 0) m_phase = P_SPAWN;
        end
      end
    endcase
    m_hit = hit_now;
  endtask

  task automatic model_check(input string tag);
    check({tag, "_cp"},    o_change_position, int'(m_phase == P_SPAWN));
    check({tag, "_vis"},   o_mole_visible,    int'(m_phase == P_UP));
    check({tag, "_hit"},   o_hit,             m_hit);
    check({tag, "_score"}, o_score,           m_score);
    check({tag, "_miss"},  o_misses,          m_miss);
    check({tag, "_over"},  o_game_over,       int'(m_phase == P_OVER));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, sample 1 ns later.
  task automatic drive(input int tick, input int start, input int diff,
                       input int wv, input int wp, input int mp);
    i_tick        = tick[0];
    i_start       = start[0];
    i_difficulty  = diff[1:0];
    i_whack_valid = wv[0];
    i_whack_pos   = wp[2:0];
    i_mole_pos    = mp[2:0];
    @(posedge i_clk);
    model_step(tick, start, diff, wv, wp, mp);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cp"},    o_change_position, 0);
    check({tag, "_vis"},   o_mole_visible,    0);
    check({tag, "_hit"},   o_hit,             0);
    check({tag, "_score"}, o_score,           0);
    check({tag, "_miss"},  o_misses,          0);
    check({tag, "_over"},  o_game_over,       0);
  endtask

  // Reset with i_start held high throughout, released between clock edges.
  task automatic do_reset();
    i_rst_n       = 1'b0;
    i_start       = 1'b1;
    i_tick        = 1'b0;
    i_whack_valid = 1'b0;
    #3;
    model_reset();
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    i_start = 1'b0;
  endtask

  initial begin
    int run;
    int rounds;
    int cp_pulses;
    int cp_after;
    int mp;
    int wp;

    // ---------------- reset state, start not latched during reset ----------
    do_reset();
    check_all_zero("rst");
    drive(0, 0, 0, 0, 0, 0);
    check_all_zero("rst_idle1");
    drive(1, 0, 0, 1, 0, 0);
    check_all_zero("rst_idle2");

    // ---------------- directed table: difficulty 0, hit on 3rd UP tick ------
    tbl[0]  = mk(0, 1, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 3, 3,  0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 3, 3,  0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 3,  0, 1, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].tick, tbl[i].start, tbl[i].diff, tbl[i].wv, tbl[i].wp, tbl[i].mp);
      check($sformatf("tbl%0d_cp", i),    o_change_position, tbl[i].cp);
      check($sformatf("tbl%0d_vis", i),   o_mole_visible,    tbl[i].vis);
      check($sformatf("tbl%0d_hit", i),   o_hit,             tbl[i].hit);
      check($sformatf("tbl%0d_score", i), o_score,           tbl[i].score);
      check($sformatf("tbl%0d_miss", i),  o_misses,          tbl[i].miss);
      check($sformatf("tbl%0d_over", i),  o_game_over,       tbl[i].over);
    end

    // ---------------- difficulty 3, no whacks: five expiries end the game ---
    do_reset();
    drive(0, 1, 3, 0, 0, 1);
    model_check("d3_start");
    run       = 0;
    rounds    = 0;
    cp_pulses = o_change_position;
    for (int n = 0; n < 200 && !o_game_over; n++) begin
      drive(1, 0, 3, 0, 0, 1);
      model_check("d3");
      cp_pulses += o_change_position;
      if (o_mole_visible) run++;
      else if (run != 0) begin
        rounds++;
        check("d3_vis_run", run, 4);
        check("d3_misses_step", o_misses, rounds);
        run = 0;
      end
    end
    check("d3_over", o_game_over, 1);
    check("d3_misses", o_misses, 5);
    check("d3_rounds", rounds, 5);
    check("d3_cp_pulses", cp_pulses, 5);
    cp_after = 0;
    for (int n = 0; n < 20; n++) begin
      drive(1, 0, 3, 1, 1, 1);
      model_check("d3_over_hold");
      cp_after += o_change_position;
    end
    check("d3_no_cp_after_over", cp_after, 0);

    // ---------------- wrong hole, then correct hole ------------------------
    do_reset();
    drive(0, 1, 0, 0, 0, 5);
    drive(0, 0, 0, 0, 0, 5);
    drive(0, 0, 0, 1, 2, 5);
    model_check("wrong");
    check("wrong_vis", o_mole_visible, 1);
    check("wrong_score", o_score, 0);
    drive(0, 0, 0, 1, 5, 5);
    model_check("right");
    check("right_hit", o_hit, 1);
    check("right_score", o_score, 1);
    check("right_miss", o_misses, 0);

    // ---------------- hit and expiry in the same cycle ---------------------
    do_reset();
    drive(0, 1, 3, 0, 0, 4);
    drive(1, 0, 3, 0, 0, 4);
    for (int n = 0; n < 3; n++) drive(1, 0, 3, 0, 0, 4);
    check("same_pre_vis", o_mole_visible, 1);
    drive(1, 0, 3, 1, 4, 4);
    model_check("same");
    check("same_hit", o_hit, 1);
    check("same_score", o_score, 1);
    check("same_miss", o_misses, 0);
    check("same_vis", o_mole_visible, 0);

    // ---------------- score saturation at 255 ------------------------------
    do_reset();
    drive(0, 1, 0, 0, 0, 3);
    for (int h = 0; h < 256; h++) begin
      for (int n = 0; n < 40 && !o_mole_visible; n++) begin
        drive(1, 0, 0, 0, 0, 3);
        model_check("sat_wait");
      end
      check("sat_up", o_mole_visible, 1);
      drive(0, 0, 0, 1, 3, 3);
      model_check("sat_hit");
      if (h == 254) check("sat_reach", o_score, 255);
    end
    check("sat_last_hit", o_hit, 1);
    check("sat_last_score", o_score, 255);

    // ---------------- randomized play against the model --------------------
    do_reset();
    mp = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) mp = $urandom_range(0, 7);
      wp = ($urandom_range(0, 1) == 0) ? mp : int'($urandom_range(0, 7));
      drive($urandom_range(0, 1), int'($urandom_range(0, 39) == 0), $urandom_range(0, 3),
            int'($urandom_range(0, 3) == 0), wp, mp);
      model_check("rnd");
    end

    // ---------------- reset mid-UP, release, fresh game --------------------
    do_reset();
    drive(0, 1, 0, 0, 0, 6);
    drive(0, 0, 0, 0, 0, 6);
    drive(0, 0, 0, 1, 6, 6);
    check("r37_pre_score", o_score, 1);
    for (int n = 0; n < 40 && !o_mole_visible; n++) drive(1, 0, 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 6);
    check("r37_in_up", o_mole_visible, 1);
    #2;
    i_rst_n = 1'b0;
    i_start = 1'b1;
    #1;
    model_reset();
    check_all_zero("r37_async");
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("r37_held");
    #1;
    i_rst_n = 1'b1;
    i_start = 1'b0;
    drive(0, 0, 0, 0, 0, 6);
    check_all_zero("r37_idle");
    drive(1, 0, 0, 1, 6, 6);
    check_all_zero("r37_idle2");
    drive(0, 1, 0, 0, 0, 6);
    model_check("r37_restart");
    check("r37_cp", o_change_position, 1);
    check("r37_score", o_score, 0);
    drive(1, 0, 0, 0, 0, 6);
    model_check("r37_up");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
